sdram_rom_frontend: RTL and testbench
=====================================

// Module: sdram_rom_frontend
// PURPOSE
//  CPU-side front end for the SDRAM ROM port. Converts byte-wide CPU read strobes and
//  16-bit loader writes into the toggle req/ack protocol (rom_req/rom_req_ack) and
//  holds read data in a tagged word buffer. Hits return without an SDRAM access.
//  Sits directly upstream of the SDRAM controller ROM port.
// PARAMETERS
//  DATA_DLY  4  clocks from observed rom_req_ack==rom_req until rom_dout is valid (CL3 slot)
//  AW        23 word-address width (rom_addr[23:1])
// PORTS
//  clk          in   1   SDRAM clock; only clock
//  init_n       in   1   asynchronous active-low reset
//  cpu_addr     in   24  CPU byte address
//  cpu_rd       in   1   1-cycle read strobe
//  cpu_dout     out  8   read byte: cpu_addr[0] ? word[15:8] : word[7:0]
//  cpu_busy     out  1   high while a read miss is outstanding
//  dl_wr        in   1   1-cycle loader word-write strobe
//  dl_addr      in   23  loader word address [23:1]
//  dl_data      in   16  loader write data
//  dl_busy      out  1   high while a loader write is outstanding
//  rom_addr     out  23  to controller, word address
//  rom_din      out  16  to controller, write data
//  rom_we       out  1   to controller, 1 = write
//  rom_req      out  1   toggle request
//  rom_req_ack  in   1   toggle acknowledge from controller
//  rom_dout     in   16  read data from controller
// BEHAVIOUR
//  - Reset: cpu_dout=0, cpu_busy=0, dl_busy=0, rom_req=0, rom_we=0, rom_addr=0,
//    rom_din=0, all buffer entries invalid, FSM=SYNC. Reset mid-transfer abandons it.
//  - SYNC (1 clk after reset release): rom_req<=rom_req_ack, discarding any stale
//    mismatch; -> IDLE.
//  - Request pending iff rom_req!=rom_req_ack. A new toggle is issued only from IDLE;
//    rom_addr/rom_din/rom_we are stable from the toggle cycle until completion.
//  - IDLE priority: loader write > CPU read miss > prefetch.
//  - Read hit (valid entry, tag==cpu_addr[23:1]): cpu_dout updated the next clock;
//    cpu_busy stays 0.
//  - Read miss: cpu_busy=1 from the next clock; FSM REQ (toggle, rom_we=0) -> ACK (wait for
//    rom_req_ack==rom_req) -> DLY (count DATA_DLY clocks) -> capture rom_dout into
//    entry 0 with its tag, drive cpu_dout, cpu_busy=0 in the same clock -> IDLE.
//  - Write: dl_busy=1 from the next clock; REQ (rom_we=1, rom_din=dl_data) -> ACK;
//    dl_busy=0 on the clock ack matches (no DLY). Every entry whose tag==dl_addr is
//    updated with dl_data (write-through, keeps buffer coherent).
//  - cpu_rd while cpu_busy=1, or dl_wr while dl_busy=1, is ignored (protocol error).
//  - dl_wr and cpu_rd in the same clock: write served first. The miss is latched
//    (cpu_busy=1) and issued immediately after the write completes.
//  - A miss raised while a prefetch is in flight waits for it (no cancel possible).
//    If its word equals the prefetch word, it completes from that fill with no second
//    access.
//  - DLY counter is 3 bits and saturates. DATA_DLY=0 captures on the ack-match clock.
//  - Address wrap: prefetch of word 0x7FFFFF targets 0x000000 (AW-bit wrap).
// CONFIGURATION
//  ROM_PREFETCH_EN defined: two entries. After every CPU miss fill, with no other work
//    pending, fetch word tag+1 into entry 1. A hit on entry 1 swaps it into entry 0 and
//    triggers the next prefetch.
//  ROM_PREFETCH_EN undefined: entry 0 only; no speculative requests; entry-1 logic absent.
// TESTING
//  - Reset, then hold rom_req_ack=1 -> after SYNC rom_req==1, no request pending, busy=0.
//  - cpu_rd addr 0x000101, model returns 0xBEEF 4 clk after ack -> one toggle,
//    cpu_dout=0xBE, cpu_busy high exactly ACK+4 clocks.
//  - Repeat cpu_rd 0x000100 -> no toggle, cpu_dout=0xEF next clock.
//  - dl_wr addr 0x000080 (word), data 0x1234, then cpu_rd 0x000100 -> one write toggle
//    with rom_we=1, entry updated; read returns 0x34, no new request.
//  - dl_wr and cpu_rd (miss, 0x000200) in the same clock -> write toggle then read toggle,
//    in that order; no overlap.
//  - ROM_PREFETCH_EN: miss 0xFFFFFE -> fill, then prefetch word 0x000000.
//    cpu_rd 0x000000 is a hit with no new request.

Source files
------------

// File: rtl/sdram_rom_frontend.sv
// rtl/sdram_rom_frontend.sv - CPU/loader front end for the SDRAM ROM port with tagged word buffer
// ROM_PREFETCH_EN adds a second entry that is filled speculatively with the next word.
module sdram_rom_frontend #(
    parameter int DATA_DLY = 4,
    parameter int AW       = 23
) (
    input  logic          clk,
    input  logic          init_n,
    input  logic [AW:0]   cpu_addr,
    input  logic          cpu_rd,
    output logic [7:0]    cpu_dout,
    output logic          cpu_busy,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [15:0]   dl_data,
    output logic          dl_busy,
    output logic [AW-1:0] rom_addr,
    output logic [15:0]   rom_din,
    output logic          rom_we,
    output logic          rom_req,
    input  logic          rom_req_ack,
    input  logic [15:0]   rom_dout
);

    typedef enum logic [2:0] {ST_SYNC, ST_IDLE, ST_REQ, ST_ACK, ST_DLY} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_PF} op_t;

    localparam logic [2:0] DLY_N = 3'(DATA_DLY);

    state_t        state, state_nxt;
    op_t           op;
    logic [2:0]    dly_cnt;
    logic [AW-1:0] miss_word, wr_addr, cpu_word;
    logic          miss_byte;
    logic [15:0]   wr_data;

    logic [AW-1:0] tag0, n_tag0;
    logic [15:0]   data0, n_data0;
    logic          v0, n_v0;
    logic          hit0, pm_hit0, hit1, pm_hit1;
    logic [15:0]   hit_word, pm_word;

    logic req_match, accept_rd, accept_wr, rd_hit, rd_miss;
    logic issue_wr, issue_rd, issue_pf, pm_done, wr_done, fill;

    function automatic logic [7:0] sel_byte(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

    assign cpu_word  = cpu_addr[AW:1];
    assign req_match = (rom_req == rom_req_ack);
    assign hit0      = v0 && (tag0 == cpu_word);
    assign pm_hit0   = v0 && (tag0 == miss_word);
    assign accept_rd = cpu_rd && !cpu_busy;
    assign accept_wr = dl_wr && !dl_busy;
    assign rd_hit    = accept_rd && (hit0 || hit1);
    assign rd_miss   = accept_rd && !(hit0 || hit1);

`ifdef ROM_PREFETCH_EN
    logic [AW-1:0] tag1, n_tag1;
    logic [15:0]   data1, n_data1;
    logic          v1, n_v1;
    logic          pf_pend, swap;

    assign hit1     = v1 && (tag1 == cpu_word);
    assign pm_hit1  = v1 && (tag1 == miss_word);
    assign hit_word = hit0 ? data0 : data1;
    assign pm_word  = pm_hit0 ? data0 : data1;
`else
    assign hit1     = 1'b0;
    assign pm_hit1  = 1'b0;
    assign hit_word = data0;
    assign pm_word  = data0;
`endif

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) state <= ST_SYNC;
        else         state <= state_nxt;
    end

    // Only IDLE starts new work: loader write, then pending CPU miss, then prefetch.
    always_comb begin
        state_nxt = state;
        issue_wr  = 1'b0;
        issue_rd  = 1'b0;
        issue_pf  = 1'b0;
        pm_done   = 1'b0;
        wr_done   = 1'b0;
        fill      = 1'b0;
        case (state)
            ST_SYNC: state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (dl_busy) begin
                    issue_wr  = 1'b1;
                    state_nxt = ST_REQ;
                end else if (cpu_busy && (pm_hit0 || pm_hit1)) begin
                    pm_done = 1'b1;
                end else if (cpu_busy) begin
                    issue_rd  = 1'b1;
                    state_nxt = ST_REQ;
                end
`ifdef ROM_PREFETCH_EN
                else if (pf_pend && !accept_rd && !accept_wr) begin
                    issue_pf  = 1'b1;
                    state_nxt = ST_REQ;
                end
`endif
            end
            ST_REQ: state_nxt = ST_ACK;
            ST_ACK: begin
                if (req_match) begin
                    if (op == OP_WR) begin
                        wr_done   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (DLY_N == 3'd0) begin
                        fill      = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_DLY;
                    end
                end
            end
            ST_DLY: begin
                if (dly_cnt >= DLY_N) begin
                    fill      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_SYNC;
        endcase
    end

    // Next buffer contents: swap on entry-1 hit, then write-through, then fill.
    always_comb begin
        n_tag0  = tag0;
        n_data0 = data0;
        n_v0    = v0;
`ifdef ROM_PREFETCH_EN
        n_tag1  = tag1;
        n_data1 = data1;
        n_v1    = v1;
        swap    = (rd_hit && !hit0) || (pm_done && !pm_hit0);
        if (swap) begin
            n_tag0  = tag1;
            n_data0 = data1;
            n_v0    = v1;
            n_tag1  = tag0;
            n_data1 = data0;
            n_v1    = v0;
        end
        if (issue_pf) n_v1 = 1'b0;
        if (wr_done && n_v1 && (n_tag1 == rom_addr)) n_data1 = rom_din;
        if (fill && (op == OP_PF)) begin
            n_tag1  = rom_addr;
            n_data1 = rom_dout;
            n_v1    = 1'b1;
        end
`endif
        if (wr_done && n_v0 && (n_tag0 == rom_addr)) n_data0 = rom_din;
        if (fill && (op == OP_RD)) begin
            n_tag0  = rom_addr;
            n_data0 = rom_dout;
            n_v0    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            op        <= OP_RD;
            dly_cnt   <= 3'd0;
            rom_req   <= 1'b0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_din   <= '0;
            cpu_dout  <= '0;
            cpu_busy  <= 1'b0;
            dl_busy   <= 1'b0;
            miss_word <= '0;
            miss_byte <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            tag0      <= '0;
            data0     <= '0;
            v0        <= 1'b0;
`ifdef ROM_PREFETCH_EN
            tag1      <= '0;
            data1     <= '0;
            v1        <= 1'b0;
            pf_pend   <= 1'b0;
`endif
        end else begin
            if (state == ST_SYNC) rom_req <= rom_req_ack;
            if (state == ST_REQ)  rom_req <= ~rom_req;
            if (issue_wr) begin
                rom_addr <= wr_addr;
                rom_din  <= wr_data;
                rom_we   <= 1'b1;
                op       <= OP_WR;
            end
            if (issue_rd) begin
                rom_addr <= miss_word;
                rom_we   <= 1'b0;
                op       <= OP_RD;
            end
            if (state == ST_ACK)        dly_cnt <= 3'd1;
            else if (dly_cnt != 3'd7)   dly_cnt <= dly_cnt + 3'd1;

            if (accept_wr) begin
                dl_busy <= 1'b1;
                wr_addr <= dl_addr;
                wr_data <= dl_data;
            end
            if (wr_done) dl_busy <= 1'b0;

            if (rd_hit) cpu_dout <= sel_byte(hit_word, cpu_addr[0]);
            if (rd_miss) begin
                cpu_busy  <= 1'b1;
                miss_word <= cpu_word;
                miss_byte <= cpu_addr[0];
            end
            if (pm_done) begin
                cpu_dout <= sel_byte(pm_word, miss_byte);
                cpu_busy <= 1'b0;
            end
            if (fill && (op == OP_RD)) begin
                cpu_dout <= sel_byte(rom_dout, miss_byte);
                cpu_busy <= 1'b0;
            end

            tag0  <= n_tag0;
            data0 <= n_data0;
            v0    <= n_v0;
`ifdef ROM_PREFETCH_EN
            tag1  <= n_tag1;
            data1 <= n_data1;
            v1    <= n_v1;
            // Address arithmetic wraps at AW bits, so word 0x7FFFFF prefetches word 0.
            if (issue_pf) begin
                rom_addr <= tag0 + AW'(1);
                rom_we   <= 1'b0;
                op       <= OP_PF;
                pf_pend  <= 1'b0;
            end
            if ((fill && (op == OP_RD)) || swap) pf_pend <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_rom_frontend.sv
// tb/tb_sdram_rom_frontend.sv - self-checking bench for sdram_rom_frontend
module tb_sdram_rom_frontend;

    localparam int DLY = 4;

    logic        clk = 1'b0;
    logic        init_n;
    logic [23:0] cpu_addr;
    logic        cpu_rd;
    logic [7:0]  cpu_dout;
    logic        cpu_busy;
    logic        dl_wr;
    logic [22:0] dl_addr;
    logic [15:0] dl_data;
    logic        dl_busy;
    logic [22:0] rom_addr;
    logic [15:0] rom_din;
    logic        rom_we;
    logic        rom_req;
    logic        rom_req_ack;
    logic [15:0] rom_dout;

    always #5 clk = ~clk;

    sdram_rom_frontend #(.DATA_DLY(DLY), .AW(23)) dut (
        .clk(clk), .init_n(init_n),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_dout(cpu_dout), .cpu_busy(cpu_busy),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_busy(dl_busy),
        .rom_addr(rom_addr), .rom_din(rom_din), .rom_we(rom_we), .rom_req(rom_req),
        .rom_req_ack(rom_req_ack), .rom_dout(rom_dout)
    );

    typedef struct {
        bit          wr;
        logic [23:0] addr;
        logic [15:0] data;
        logic [7:0]  exp_b;
        int          exp_tog;
        bit          chk_lat;
    } vec_t;

    int checks = 0, errors = 0;
    int cyc = 0, tog_cnt = 0, overlap = 0;
    int last_ack_cyc = 0, last_wr_ack_cyc = 0;
    bit ctl_en = 1'b0, mon_en = 1'b0;
    logic prev_req, prev_ack, last_we;
    logic [22:0] last_addr;
    logic we_q[$];
    logic [15:0] sdram [int];
    logic [15:0] model [int];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_word(input logic [22:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] sd_rd(input logic [22:0] a);
        return sdram.exists(int'(a)) ? sdram[int'(a)] : init_word(a);
    endfunction

    function automatic logic [15:0] mdl_rd(input logic [22:0] a);
        return model.exists(int'(a)) ? model[int'(a)] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SDRAM controller model: random ack latency, data valid only DLY clocks after ack.
    initial begin : ctl
        logic [22:0] a;
        rom_req_ack = 1'b1;
        rom_dout    = 16'hDEAD;
        forever begin
            @(negedge clk);
            rom_dout = 16'hDEAD;
            if (ctl_en && (rom_req != rom_req_ack)) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                a = rom_addr;
                if (rom_we) begin
                    sdram[int'(a)] = rom_din;
                    last_wr_ack_cyc = cyc;
                    rom_req_ack = rom_req;
                end else begin
                    rom_req_ack = rom_req;
                    last_ack_cyc = cyc;
                    for (int k = 0; k <= DLY; k++) begin
                        rom_dout = (k == DLY) ? sd_rd(a) : ~sd_rd(a);
                        if (k < DLY) @(negedge clk);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (rom_req != prev_req) begin
                tog_cnt++;
                if (prev_req != prev_ack) overlap++;
                we_q.push_back(rom_we);
                last_we   = rom_we;
                last_addr = rom_addr;
            end
            prev_req = rom_req;
            prev_ack = rom_req_ack;
        end
    end

    task automatic do_read(input logic [23:0] a, output logic [7:0] b, output int tog,
                           output int lat, output bit busy_seen);
        int t0, n;
        @(negedge clk);
        t0 = tog_cnt;
        cpu_addr = a;
        cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        busy_seen = cpu_busy;
        n = 0;
        while (cpu_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rd_done", cpu_busy, 1'b0);
        lat = cyc - last_ack_cyc;
        b = cpu_dout;
        repeat (16) @(negedge clk);
        tog = tog_cnt - t0;
    endtask

    task automatic do_write(input logic [22:0] w, input logic [15:0] d, output int tog, output int lat);
        int t0, n;
        @(negedge clk);
        t0 = tog_cnt;
        dl_addr = w;
        dl_data = d;
        dl_wr = 1'b1;
        @(negedge clk);
        dl_wr = 1'b0;
        chk("wr_busy", dl_busy, 1'b1);
        model[int'(w)] = d;
        n = 0;
        while (dl_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wr_done", dl_busy, 1'b0);
        lat = cyc - last_wr_ack_cyc;
        repeat (16) @(negedge clk);
        tog = tog_cnt - t0;
        chk("wr_we", last_we, 1'b1);
        chk("wr_addr", last_addr, w);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t vecs[6];
        logic [7:0]  b, exp_b;
        logic [15:0] d, wv;
        logic [22:0] w, last_word;
        logic [22:0] pool[4];
        int tog, lat, pfx, n, t0;
        bit bs, hi;

        pfx = 0;
`ifdef ROM_PREFETCH_EN
        pfx = 1;
`endif
        vecs[0] = '{wr:0, addr:24'h000101, data:16'h0,    exp_b:8'hBE, exp_tog:1, chk_lat:1};
        vecs[1] = '{wr:0, addr:24'h000100, data:16'h0,    exp_b:8'hEF, exp_tog:0, chk_lat:0};
        vecs[2] = '{wr:1, addr:24'h000080, data:16'h1234, exp_b:8'h00, exp_tog:1, chk_lat:0};
        vecs[3] = '{wr:0, addr:24'h000100, data:16'h0,    exp_b:8'h34, exp_tog:0, chk_lat:0};
        vecs[4] = '{wr:0, addr:24'h000201, data:16'h0,    exp_b:8'hCA, exp_tog:1, chk_lat:1};
        vecs[5] = '{wr:0, addr:24'h000101, data:16'h0,    exp_b:8'h12, exp_tog:1, chk_lat:0};
        sdram[int'(23'h80)]  = 16'hBEEF;
        model[int'(23'h80)]  = 16'hBEEF;
        sdram[int'(23'h100)] = 16'hCAFE;
        model[int'(23'h100)] = 16'hCAFE;

        init_n = 1'b0;
        cpu_addr = '0;
        cpu_rd = 1'b0;
        dl_wr = 1'b0;
        dl_addr = '0;
        dl_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_dout", cpu_dout, 8'h00);
        chk("rst_cpu_busy", cpu_busy, 1'b0);
        chk("rst_dl_busy", dl_busy, 1'b0);
        chk("rst_rom_req", rom_req, 1'b0);
        chk("rst_rom_we", rom_we, 1'b0);
        chk("rst_rom_addr", rom_addr, 23'h0);
        chk("rst_rom_din", rom_din, 16'h0);
        init_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("sync_rom_req", rom_req, 1'b1);
        chk("sync_pending", rom_req ^ rom_req_ack, 1'b0);
        chk("sync_busy", {cpu_busy, dl_busy}, 2'b00);
        prev_req = rom_req;
        prev_ack = rom_req_ack;
        mon_en = 1'b1;
        ctl_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr[22:0], vecs[i].data, tog, lat);
                chk($sformatf("v%0d_tog", i), tog, vecs[i].exp_tog);
                chk($sformatf("v%0d_wlat", i), lat, 1);
            end else begin
                do_read(vecs[i].addr, b, tog, lat, bs);
                chk($sformatf("v%0d_data", i), b, vecs[i].exp_b);
                chk($sformatf("v%0d_tog", i), tog, vecs[i].exp_tog + ((vecs[i].exp_tog == 1) ? pfx : 0));
                chk($sformatf("v%0d_busy", i), bs, vecs[i].exp_tog > 0);
                if (vecs[i].chk_lat) chk($sformatf("v%0d_lat", i), lat, DLY + 1);
            end
        end

        // Simultaneous loader write and CPU read miss: write toggles first.
        @(negedge clk);
        t0 = tog_cnt;
        we_q.delete();
        dl_addr = 23'h90;
        dl_data = 16'h5555;
        dl_wr = 1'b1;
        cpu_addr = 24'h000200;
        cpu_rd = 1'b1;
        model[int'(23'h90)] = 16'h5555;
        @(negedge clk);
        dl_wr = 1'b0;
        cpu_rd = 1'b0;
        chk("simul_cpu_busy", cpu_busy, 1'b1);
        chk("simul_dl_busy", dl_busy, 1'b1);
        n = 0;
        while ((cpu_busy || dl_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("simul_done", {cpu_busy, dl_busy}, 2'b00);
        chk("simul_data", cpu_dout, 8'hFE);
        repeat (16) @(negedge clk);
        chk("simul_tog", tog_cnt - t0, 2 + pfx);
        if (we_q.size() >= 2) begin
            chk("simul_first_we", we_q[0], 1'b1);
            chk("simul_second_we", we_q[1], 1'b0);
        end
        wv = sd_rd(23'h90);
        chk("simul_sdram", wv, 16'h5555);

        // Random traffic against the memory model; demand buffer tracks the last missed word.
        pool[0] = 23'h100;
        pool[1] = 23'h101;
        pool[2] = 23'h102;
        pool[3] = 23'h80;
        last_word = 23'h100;
        for (int i = 0; i < 40; i++) begin
            w = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 2) == 0) begin
                d = 16'($urandom);
                do_write(w, d, tog, lat);
                chk($sformatf("r%0d_wtog", i), tog, 1);
            end else begin
                hi = 1'($urandom_range(0, 1));
                do_read({w, hi}, b, tog, lat, bs);
                wv = mdl_rd(w);
                exp_b = hi ? wv[15:8] : wv[7:0];
                chk($sformatf("r%0d_data", i), b, exp_b);
`ifndef ROM_PREFETCH_EN
                chk($sformatf("r%0d_tog", i), tog, (w == last_word) ? 0 : 1);
                last_word = w;
`endif
            end
        end

`ifdef ROM_PREFETCH_EN
        do_read(24'hFFFFFE, b, tog, lat, bs);
        wv = init_word(23'h7FFFFF);
        chk("pf_wrap_data", b, wv[7:0]);
        chk("pf_wrap_tog", tog, 2);
        chk("pf_wrap_addr", last_addr, 23'h0);
        do_read(24'h000000, b, tog, lat, bs);
        wv = init_word(23'h0);
        chk("pf_hit_data", b, wv[7:0]);
        chk("pf_hit_busy", bs, 1'b0);
        chk("pf_next_addr", last_addr, 23'h1);
`endif

        chk("no_overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
